effect_scheduler: RTL and testbench
===================================

// Module: effect_scheduler
// PURPOSE
//   Controller for the 7-digit display effect datapath: produces the shared effect-select
//   code (enable) and speed code (frequency) fed to all effect modules. Handles mode/speed/auto
//   buttons, auto-cycling of effects after a dwell time, and a blanking gap between effects
//   so the selected effect starts from its first frame.
// PARAMETERS
//   NUM_EFFECTS      4            number of effects, legal 1..7; codes 0..NUM_EFFECTS-1
//   DWELL_CYCLES     500000000    clk cycles in RUN before auto-advance (10 s @ 50 MHz)
//   BLANK_CYCLES     25000000     clk cycles enable is held at blank code 3'b111
//   DEBOUNCE_CYCLES  1000000      stable-level cycles for debounce (used only with DEBOUNCE_EN)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  asynchronous reset, active-high
//   btn_mode   in   1  async button level, 1 = pressed: advance to next effect
//   btn_speed  in   1  async button level: step frequency code
//   btn_auto   in   1  async button level: toggle auto-cycle mode
//   enable     out  3  effect select to effect modules; 3'b111 = blank (no effect active)
//   frequency  out  2  speed code: 00 0.5 Hz, 01 1 Hz, 10 2 Hz, 11 4 Hz
//   auto_mode  out  1  1 = auto-cycling active
//   blanking   out  1  1 while in BLANK state (enable == 3'b111)
// BEHAVIOUR
//   - Reset (async, immediate, any state): enable=3'b000, frequency=2'b01, auto_mode=0,
//     blanking=0, state=RUN, dwell/blank counters=0, synchronizer/edge flops=0.
//   - Inputs: each button through 2-flop synchronizer; press event = rising edge of the
//     synchronized (or filtered) level, one cycle wide. Press events never queue.
//   - Latency (no DEBOUNCE_EN): input high at sampling edge 1 -> outputs update at edge 3.
//   - FSM RUN: enable = current index. Advance request = mode press OR (auto_mode AND
//     dwell == DWELL_CYCLES-1). On advance: index <= (index==NUM_EFFECTS-1) ? 0 : index+1,
//     enable <= 3'b111, blanking <= 1, blank counter <= 0, dwell <= 0, state <= BLANK.
//   - Dwell counter: increments each RUN cycle only while auto_mode=1; held at 0 otherwise;
//     cleared on advance and on auto toggle.
//   - FSM BLANK: blank counter increments; at BLANK_CYCLES-1 -> enable <= index, blanking <= 0,
//     state <= RUN. Mode presses in BLANK are dropped; dwell does not count in BLANK.
//   - Speed press (any state): frequency <= frequency+1, wraps 11 -> 00.
//   - Auto press (any state): auto_mode toggles.
//   - Simultaneous: mode press + dwell expiry = single advance; speed/auto presses apply in the
//     same cycle as an advance independently.
//   - NUM_EFFECTS=1: advance goes 0 -> BLANK -> 0. Counter widths via $clog2, min 1 bit.
// CONFIGURATION
//   DEBOUNCE_EN defined: after sync, each button level feeds a filter; filtered level updates
//     only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles
//     (counter restarts on any bounce). Press = rising edge of filtered level; adds
//     DEBOUNCE_CYCLES cycles of latency.
//   DEBOUNCE_EN undefined: no filter, DEBOUNCE_CYCLES ignored; every synchronized rising edge
//     is a press.
// TESTING  (NUM_EFFECTS=4, DWELL_CYCLES=20, BLANK_CYCLES=5, DEBOUNCE_CYCLES=4)
//   1 Assert rst mid-BLANK with frequency=11, auto_mode=1 -> same instant enable=000,
//     frequency=01, auto_mode=0, blanking=0; holds until first press after release.
//   2 Four mode presses, spaced >=10 cycles -> enable 000,111x5,001,111x5,010,111x5,011,
//     111x5,000 (wrap); blanking high exactly during each 5-cycle 111 window.
//   3 Four speed presses from reset -> frequency 10,11,00,01; press during BLANK also steps.
//   4 Auto press, no other input -> enable advances after 20 RUN cycles, 5 blank cycles,
//     repeats (period 25); second auto press -> auto_mode=0, enable frozen indefinitely.
//   5 Mode press inside BLANK -> ignored (single advance); mode press on the dwell-expiry
//     cycle -> exactly one advance, index +1.
//   6 DEBOUNCE_EN: 2-cycle btn_mode glitch -> no change; 8-cycle press -> exactly one advance,
//     enable = 111 at sampling edge + 2 + 4 + 1 edges.

Source files
------------

// File: rtl/effect_scheduler.sv
// Effect/speed controller for the 7-digit display effects: button handling, auto-cycle dwell
// and a blanking gap between effects. Optional button debounce filter via `define DEBOUNCE_EN.
module effect_scheduler #(
    parameter int NUM_EFFECTS     = 4,
    parameter int DWELL_CYCLES    = 500000000,
    parameter int BLANK_CYCLES    = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       btn_auto,
    output logic [2:0] enable,
    output logic [1:0] frequency,
    output logic       auto_mode,
    output logic       blanking
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_EFFECTS - 1);

    // Button vectors are ordered {auto, speed, mode}.
    logic [2:0] sync1, sync2, lvl, lvl_d, press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_d <= '0;
        end else begin
            sync1 <= {btn_auto, btn_speed, btn_mode};
            sync2 <= sync1;
            lvl_d <= lvl;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int KW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [KW-1:0] DEB_LAST = KW'(DEBOUNCE_CYCLES - 1);
    logic [2:0]    filt;
    logic [KW-1:0] deb_cnt [3];

    // Filtered level follows the synchronized level only after it has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    assign press = lvl & ~lvl_d;

    // blanking is the externally visible copy of the BLANK state.
    typedef enum logic {RUN, BLANK} state_t;
    state_t          state, state_n;
    logic [2:0]      idx, idx_n, enable_n;
    logic [1:0]      frequency_n;
    logic            auto_mode_n, blanking_n, advance;
    logic [DW-1:0]   dwell, dwell_n;
    logic [BW-1:0]   blank_cnt, blank_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            idx       <= '0;
            enable    <= 3'b000;
            frequency <= 2'b01;
            auto_mode <= 1'b0;
            blanking  <= 1'b0;
            dwell     <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            enable    <= enable_n;
            frequency <= frequency_n;
            auto_mode <= auto_mode_n;
            blanking  <= blanking_n;
            dwell     <= dwell_n;
            blank_cnt <= blank_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        enable_n    = enable;
        frequency_n = frequency;
        auto_mode_n = auto_mode;
        blanking_n  = blanking;
        dwell_n     = dwell;
        blank_cnt_n = blank_cnt;
        advance     = 1'b0;

        if (press[1]) frequency_n = frequency + 2'd1;
        if (press[2]) auto_mode_n = ~auto_mode;

        case (state)
            RUN: begin
                advance = press[0] | (auto_mode && (dwell == DWELL_LAST));
                dwell_n = auto_mode ? dwell + 1'b1 : '0;
                if (advance) begin
                    idx_n       = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                    enable_n    = 3'b111;
                    blanking_n  = 1'b1;
                    blank_cnt_n = '0;
                    dwell_n     = '0;
                    state_n     = BLANK;
                end
            end
            BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    enable_n   = idx;
                    blanking_n = 1'b0;
                    state_n    = RUN;
                end else begin
                    blank_cnt_n = blank_cnt + 1'b1;
                end
            end
            default: state_n = RUN;
        endcase

        // An auto toggle always restarts the dwell period.
        if (press[2]) dwell_n = '0;
    end

endmodule

// File: tb/tb_effect_scheduler.sv
// Self-checking bench for effect_scheduler with small timing parameters.
// Default build checks the unfiltered path; with DEBOUNCE_EN it checks the debounce filter.
module tb_effect_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_speed, btn_auto;
    logic [2:0] enable;
    logic [1:0] frequency;
    logic       auto_mode, blanking;

    int checks   = 0;
    int failures = 0;

    effect_scheduler #(
        .NUM_EFFECTS(4), .DWELL_CYCLES(20), .BLANK_CYCLES(5), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_speed(btn_speed), .btn_auto(btn_auto),
        .enable(enable), .frequency(frequency), .auto_mode(auto_mode), .blanking(blanking)
    );

    always #5 clk = ~clk;

    // Each record: buttons {mode,speed,auto} applied after an edge, edges to advance,
    // then expected {enable, frequency, auto_mode, blanking}.
    typedef struct {
        logic [2:0] btn;
        int         cyc;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [38];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {enable, frequency, auto_mode, blanking};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got en=%b fr=%b au=%b bl=%b, want en=%b fr=%b au=%b bl=%b",
                     name, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic set_btn(input logic [2:0] b);
        {btn_mode, btn_speed, btn_auto} = b;
    endtask

    initial begin
        //            btn     cyc  en    fr  au bl        edge after step
        vecs[0]  = '{3'b100, 1,  7'b000_01_0_0};  // e1 mode sampled
        vecs[1]  = '{3'b000, 1,  7'b000_01_0_0};  // e2
        vecs[2]  = '{3'b000, 1,  7'b111_01_0_1};  // e3 advance
        vecs[3]  = '{3'b000, 4,  7'b111_01_0_1};  // e7 last blank cycle
        vecs[4]  = '{3'b000, 1,  7'b001_01_0_0};  // e8 effect 1
        vecs[5]  = '{3'b010, 2,  7'b001_01_0_0};  // e10 speed held 2 cycles
        vecs[6]  = '{3'b000, 1,  7'b001_10_0_0};  // e11 one step
        vecs[7]  = '{3'b000, 3,  7'b001_10_0_0};  // e14 no second step
        vecs[8]  = '{3'b100, 1,  7'b001_10_0_0};  // e15
        vecs[9]  = '{3'b000, 2,  7'b111_10_0_1};  // e17 advance to 2
        vecs[10] = '{3'b110, 1,  7'b111_10_0_1};  // e18 mode+speed during blank
        vecs[11] = '{3'b000, 2,  7'b111_11_0_1};  // e20 speed steps in blank
        vecs[12] = '{3'b000, 1,  7'b111_11_0_1};  // e21
        vecs[13] = '{3'b000, 1,  7'b010_11_0_0};  // e22 effect 2
        vecs[14] = '{3'b000, 5,  7'b010_11_0_0};  // e27 blank-time mode dropped
        vecs[15] = '{3'b010, 1,  7'b010_11_0_0};  // e28
        vecs[16] = '{3'b000, 2,  7'b010_00_0_0};  // e30 speed wraps 11->00
        vecs[17] = '{3'b001, 1,  7'b010_00_0_0};  // e31 auto
        vecs[18] = '{3'b000, 1,  7'b010_00_0_0};  // e32
        vecs[19] = '{3'b000, 1,  7'b010_00_1_0};  // e33 auto on
        vecs[20] = '{3'b000, 19, 7'b010_00_1_0};  // e52 dwell not yet expired
        vecs[21] = '{3'b000, 1,  7'b111_00_1_1};  // e53 auto advance
        vecs[22] = '{3'b000, 4,  7'b111_00_1_1};  // e57
        vecs[23] = '{3'b000, 1,  7'b011_00_1_0};  // e58 effect 3
        vecs[24] = '{3'b000, 17, 7'b011_00_1_0};  // e75
        vecs[25] = '{3'b100, 1,  7'b011_00_1_0};  // e76 mode timed onto expiry
        vecs[26] = '{3'b000, 1,  7'b011_00_1_0};  // e77
        vecs[27] = '{3'b000, 1,  7'b111_00_1_1};  // e78 single advance
        vecs[28] = '{3'b000, 4,  7'b111_00_1_1};  // e82
        vecs[29] = '{3'b000, 1,  7'b000_00_1_0};  // e83 wrap to 0, not 1
        vecs[30] = '{3'b000, 19, 7'b000_00_1_0};  // e102
        vecs[31] = '{3'b000, 1,  7'b111_00_1_1};  // e103 period 25
        vecs[32] = '{3'b001, 1,  7'b111_00_1_1};  // e104 auto press in blank
        vecs[33] = '{3'b000, 1,  7'b111_00_1_1};  // e105
        vecs[34] = '{3'b000, 1,  7'b111_00_0_1};  // e106 auto off
        vecs[35] = '{3'b000, 1,  7'b111_00_0_1};  // e107
        vecs[36] = '{3'b000, 1,  7'b001_00_0_0};  // e108 effect 1
        vecs[37] = '{3'b000, 60, 7'b001_00_0_0};  // e168 frozen

        rst = 1'b1;
        set_btn(3'b000);
        tick(3);
        check("reset_state", 7'b000_01_0_0);
        rst = 1'b0;
        tick(2);
        check("post_reset_idle", 7'b000_01_0_0);

`ifdef DEBOUNCE_EN
        set_btn(3'b100);
        tick(2);
        set_btn(3'b000);
        tick(12);
        check("deb_glitch_ignored", 7'b000_01_0_0);
        set_btn(3'b100);
        tick(6);
        check("deb_before_press", 7'b000_01_0_0);
        tick(1);
        check("deb_press_edge7", 7'b111_01_0_1);
        tick(1);
        set_btn(3'b000);
        tick(20);
        check("deb_single_advance", 7'b001_01_0_0);
`else
        for (int i = 0; i < 38; i++) begin
            set_btn(vecs[i].btn);
            tick(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of BLANK with frequency=11 and auto_mode=1.
        for (int k = 0; k < 3; k++) begin
            set_btn(3'b010);
            tick(1);
            set_btn(3'b000);
            tick(3);
        end
        set_btn(3'b100);
        tick(1);
        set_btn(3'b001);
        tick(1);
        set_btn(3'b000);
        tick(2);
        check("pre_reset_blank", 7'b111_11_1_1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_immediate", 7'b000_01_0_0);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("reset_holds", 7'b000_01_0_0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
